// File: rtl/mem_region_pkg.sv
// mem_region_pkg: shared request type, external-DRAM FSM states and region decode
// for mem_region_ctrl.
package mem_region_pkg;
  localparam int XLEN_DEF = 32;
  localparam int ADDR_BITS_DEF = 24;

  typedef struct packed {
    logic [ADDR_BITS_DEF-1:0] addr;
    logic                     is_write;
    logic [XLEN_DEF/8-1:0]    byte_en;
    logic [XLEN_DEF-1:0]      data;
  } dram_req_t;

  typedef enum logic [1:0] {EXT_IDLE, EXT_ISSUE, EXT_WAIT_ACK, EXT_FLUSH} ext_state_t;

  function automatic logic is_dram_region(input logic [31:0] addr, input int unsigned sram_words);
    return addr >= sram_words;
  endfunction
endpackage

// File: rtl/dram_req_fifo.sv
// dram_req_fifo: in-order synchronous FIFO of DRAM requests with a synchronous flush;
// pointers carry one extra wrap bit so full and empty are distinguishable.
module dram_req_fifo import mem_region_pkg::*; #(
  parameter int  DEPTH = 4,
  parameter type T     = dram_req_t
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  T                         i_din,
  input  logic                     i_pop,
  output T                         o_dout,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int AW = $clog2(DEPTH);
  T r_mem [DEPTH];
  logic [AW:0] r_wr, r_rd;
  logic w_push, w_pop;

  assign o_count = r_wr - r_rd;
  assign o_full  = o_count == (AW+1)'(DEPTH);
  assign o_empty = r_wr == r_rd;
  assign o_dout  = r_mem[r_rd[AW-1:0]];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else if (i_flush) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
    end

  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr[AW-1:0]] <= i_din;
endmodule

// File: rtl/mem_region_ctrl_sram.sv
// mem_region_ctrl_sram: 16-bit single-port RAM block with per-byte write enables
// and a registered read port (one cycle of read latency).
module mem_region_ctrl_sram #(
  parameter int WORDS = 8192,
  parameter int AW    = 13
) (
  input  logic          clk,
  input  logic          i_re,
  input  logic [1:0]    i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [15:0]   i_wdata,
  output logic [15:0]   o_rdata
);
  logic [15:0] r_mem [WORDS];

  always_ff @(posedge clk) begin
    if (i_we[0]) r_mem[i_addr][7:0] <= i_wdata[7:0];
    if (i_we[1]) r_mem[i_addr][15:8] <= i_wdata[15:8];
    if (i_re) o_rdata <= r_mem[i_addr];
  end
endmodule

// File: rtl/mem_region_ctrl.sv
// mem_region_ctrl: splits core word requests between on-chip SRAM and a queued external DRAM path.
// MEM_REGION_CTRL_POSTED_WRITE_EN: ack DRAM writes on FIFO push instead of on ext_dram_ack.
module mem_region_ctrl import mem_region_pkg::*; #(
  parameter int          XLEN         = 32,
  parameter int          ADDR_BITS    = 24,
  parameter int unsigned SRAM_WORDS   = 8192,
  parameter int          SRAM_RD_LAT  = 1,
  parameter int          DRAM_Q_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sync_reset,
  input  logic [ADDR_BITS-1:0] mem_addr,
  input  logic                 mem_read_en,
  input  logic [XLEN/8-1:0]    mem_write_en,
  input  logic [XLEN-1:0]      mem_write_data,
  output logic [XLEN-1:0]      mem_read_data,
  output logic                 mem_read_ack,
  output logic                 mem_write_ack,
  output logic [ADDR_BITS-1:0] mem_addr_ack,
  output logic                 mem_busy,
  output logic                 dram_rw_pending,
  output logic [ADDR_BITS-1:0] ext_dram_mem_addr,
  output logic                 ext_dram_mem_read_en,
  output logic                 ext_dram_mem_write_en,
  output logic [XLEN/8-1:0]    ext_dram_mem_byte_enable,
  output logic [XLEN-1:0]      ext_dram_mem_write_data,
  input  logic                 ext_dram_ack,
  input  logic [XLEN-1:0]      ext_dram_mem_read_data
);
  localparam int QW = $clog2(DRAM_Q_DEPTH);

  typedef struct packed {
    logic [ADDR_BITS-1:0] addr;
    logic                 is_write;
    logic [XLEN/8-1:0]    byte_en;
    logic [XLEN-1:0]      data;
  } req_t;

  ext_state_t r_state, w_next;
  req_t r_cur, w_din, w_dout, w_cur;
  logic [QW:0] w_count;
  logic w_wr, w_rd, w_dram, w_push, w_pop, w_full, w_empty, w_more;
  logic w_ext_done, w_ret, w_dram_wack, w_sram_wr, w_sram_rd, w_sram_ack;
  logic r_wack, r_whold, r_dv, r_v1;
  logic [XLEN-1:0] r_dd, w_ram_q, w_sram_data;
  logic [ADDR_BITS-1:0] r_da, r_a1, w_sram_addr;

  assign w_wr      = |mem_write_en;
  assign w_rd      = mem_read_en & ~w_wr;
  assign w_dram    = is_dram_region(32'(mem_addr), SRAM_WORDS);
  assign w_push    = (w_wr | w_rd) & w_dram & ~w_full & ~sync_reset;
  assign w_din     = {mem_addr, w_wr, mem_write_en, mem_write_data};
  assign w_sram_wr = w_wr & ~w_dram & ~sync_reset;
  assign w_sram_rd = w_rd & ~w_dram & ~sync_reset;

  dram_req_fifo #(.DEPTH(DRAM_Q_DEPTH), .T(req_t)) u_fifo (
    .clk(clk), .rst_n(reset_n), .i_flush(sync_reset), .i_push(w_push), .i_din(w_din),
    .i_pop(w_pop), .o_dout(w_dout), .o_count(w_count), .o_full(w_full), .o_empty(w_empty)
  );

  assign w_pop      = r_state == EXT_ISSUE;
  assign w_more     = ~sync_reset & (w_push | ~w_empty);
  assign w_ext_done = (r_state == EXT_WAIT_ACK) & ext_dram_ack & ~sync_reset;
  assign w_ret      = w_ext_done & ~r_cur.is_write;

  always_comb begin
    w_next = r_state;
    case (r_state)
      EXT_IDLE:     w_next = w_more ? EXT_ISSUE : EXT_IDLE;
      EXT_ISSUE:    w_next = sync_reset ? EXT_FLUSH : EXT_WAIT_ACK;
      EXT_WAIT_ACK: w_next = ext_dram_ack ? (w_more ? EXT_ISSUE : EXT_IDLE) :
                             sync_reset ? EXT_FLUSH : EXT_WAIT_ACK;
      EXT_FLUSH:    w_next = ext_dram_ack ? EXT_IDLE : EXT_FLUSH;
      default:      w_next = EXT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state <= EXT_IDLE;
      r_cur   <= '0;
    end else begin
      r_state <= w_next;
      if (w_pop) r_cur <= w_dout;
    end

  // The head entry drives the bus during ISSUE; r_cur holds it until the ack.
  assign w_cur                    = w_pop ? w_dout : r_cur;
  assign ext_dram_mem_addr        = w_cur.addr;
  assign ext_dram_mem_byte_enable = w_cur.byte_en;
  assign ext_dram_mem_write_data  = w_cur.data;
  assign ext_dram_mem_read_en     = w_pop & ~w_cur.is_write;
  assign ext_dram_mem_write_en    = w_pop & w_cur.is_write;

`ifdef MEM_REGION_CTRL_POSTED_WRITE_EN
  assign w_dram_wack = w_push & w_wr;
`else
  assign w_dram_wack = w_ext_done & r_cur.is_write;
`endif

  // A colliding SRAM write ack and DRAM write completion are serialised via r_whold.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_wack  <= 1'b0;
      r_whold <= 1'b0;
      r_dv    <= 1'b0;
      r_dd    <= '0;
      r_da    <= '0;
      r_v1    <= 1'b0;
      r_a1    <= '0;
    end else begin
      r_wack  <= ~sync_reset & (w_sram_wr | w_dram_wack | r_whold);
      r_whold <= ~sync_reset & w_sram_wr & w_dram_wack;
      r_dv    <= ~sync_reset & (w_ret | (r_dv & w_sram_ack));
      r_v1    <= w_sram_rd;
      if (w_ret) begin
        r_dd <= ext_dram_mem_read_data;
        r_da <= r_cur.addr;
      end
      if (w_sram_rd) r_a1 <= mem_addr;
    end

  generate
    if (SRAM_WORDS > 0) begin : g_sram
      localparam int SAW = SRAM_WORDS > 1 ? $clog2(SRAM_WORDS) : 1;
      for (genvar h = 0; h < XLEN/16; h++) begin : g_half
        mem_region_ctrl_sram #(.WORDS(SRAM_WORDS), .AW(SAW)) u_ram (
          .clk(clk), .i_re(w_sram_rd), .i_we(mem_write_en[2*h +: 2] & {2{w_sram_wr}}),
          .i_addr(mem_addr[SAW-1:0]), .i_wdata(mem_write_data[16*h +: 16]),
          .o_rdata(w_ram_q[16*h +: 16])
        );
      end
    end else begin : g_no_sram
      assign w_ram_q = '0;
    end
    if (SRAM_RD_LAT == 2) begin : g_lat2
      logic r_v2;
      logic [ADDR_BITS-1:0] r_a2;
      logic [XLEN-1:0] r_d2;
      always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
          r_v2 <= 1'b0;
          r_a2 <= '0;
          r_d2 <= '0;
        end else begin
          r_v2 <= r_v1 & ~sync_reset;
          r_a2 <= r_a1;
          r_d2 <= w_ram_q;
        end
      assign w_sram_ack  = r_v2;
      assign w_sram_addr = r_a2;
      assign w_sram_data = r_d2;
    end else begin : g_lat1
      assign w_sram_ack  = r_v1;
      assign w_sram_addr = r_a1;
      assign w_sram_data = w_ram_q;
    end
  endgenerate

  assign mem_read_ack    = w_sram_ack | r_dv;
  assign mem_read_data   = w_sram_ack ? w_sram_data : r_dd;
  assign mem_addr_ack    = w_sram_ack ? w_sram_addr : r_da;
  assign mem_write_ack   = r_wack;
  assign mem_busy        = w_full;
  assign dram_rw_pending = (w_count != '0) | (r_state != EXT_IDLE);
endmodule
